// File: rtl/alu_share_ctrl_pkg.sv
// Shared definitions for the ALU sharing controller: ALU control encodings,
// the sequencer state type and a small one-hot helper.
package alu_share_ctrl_pkg;

  // ALU control encodings. Codes outside this set are forwarded unchanged;
  // the ALU answers them with result 0 and zero=1.
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Sequencer states: wait for a request, let the ALU evaluate, hold the response.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // One-hot vector for a two-requester index.
  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu_share_ctrl_rr_arb2.sv
// Two-input combinational round-robin picker. On a tie the requester that did
// not win most recently is chosen; a lone requester always wins.
module rr_arb2
  import alu_share_ctrl_pkg::*;
(
  input  logic [1:0] req_valid,
  input  logic       last,
  output logic [1:0] grant,
  output logic       winner
);

  // Pick the winner index and expand it to a one-hot grant.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    winner = 1'b0;
    grant  = 2'b00;
    case (req_valid)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last;
      default: winner = 1'b0;
    endcase
    if (req_valid != 2'b00) begin
      grant = onehot2(winner);
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one single-cycle ALU between two requesters. A three-state sequencer
// accepts a request, registers its operands into the ALU, captures the result
// one cycle later and holds it until the owning requester takes it. A new
// request may be accepted in the same cycle the previous response completes.
module alu_share_ctrl
  import alu_share_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  input  logic [2:0]       req_ctl0,
  input  logic [2:0]       req_ctl1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic [WIDTH-1:0] alu_srca,
  output logic [WIDTH-1:0] alu_srcb,
  output logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero
);

  state_t           state;
  state_t           state_next;
  // Most recent winner. Because every accept updates it, it also names the
  // owner of the transaction currently in EXEC or RESP.
  logic             last;
  logic [1:0]       grant;
  logic             winner;
  logic             rsp_done;
  logic             accept;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [2:0]       sel_ctl;

  rr_arb2 u_arb (
    .req_valid (req_valid),
    .last      (last),
    .grant     (grant),
    .winner    (winner)
  );

  // Response handshake and accept qualification.
  always_comb begin
    rsp_done = (state == S_RESP) && rsp_ready[last];
    accept   = (req_valid != 2'b00) && ((state == S_IDLE) || rsp_done);
  end

  // Operand mux: route the winning requester's operands toward the ALU registers.
  always_comb begin
    sel_a   = winner ? req_a1   : req_a0;
    sel_b   = winner ? req_b1   : req_b0;
    sel_ctl = winner ? req_ctl1 : req_ctl0;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (accept) state_next = S_EXEC;
      S_EXEC: state_next = S_RESP;
      S_RESP: begin
        if (rsp_done) begin
          state_next = accept ? S_EXEC : S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Output logic: grant is presented only when an accept actually happens.
  always_comb begin
    req_ready = accept ? grant : 2'b00;
  end

  // Operand registers and round-robin pointer; they move only on an accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_srca    <= '0;
      alu_srcb    <= '0;
      alu_control <= 3'b000;
      last        <= 1'b1;
    end else if (accept) begin
      alu_srca    <= sel_a;
      alu_srcb    <= sel_b;
      alu_control <= sel_ctl;
      last        <= winner;
    end
  end

  // Response registers: capture at the end of EXEC, release on the handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid  <= 2'b00;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
    end else if (state == S_EXEC) begin
      rsp_valid  <= onehot2(last);
      rsp_result <= alu_result;
      rsp_zero   <= alu_zero;
    end else if (rsp_done) begin
      rsp_valid  <= 2'b00;
    end
  end

endmodule
